// File: rtl/mem_array_scan_if.sv
// ---------------------------------------------------------------------------
// mem_array_scan_if
//   Bundles the random-access and scan-stream signals of mem_array_scan.
//   The clock and reset stay plain ports on the modules that use this.
//
//   Random-access write : _wr_en, _wr_row, _wr_column, _wr_data
//   Random-access read  : _rd_en, _row, _column -> _value, _rd_valid
//   Scan stream         : _scan_start, _scan_ready -> _scan_valid,
//                         _scan_data, _scan_row, _scan_column, _scan_last
//   Status              : _busy
//
//   master : the controller / consumer side (drives strobes and ready)
//   slave  : the memory array side
// ---------------------------------------------------------------------------
interface mem_array_scan_if #(
   parameter int WIDTH = 8,
   parameter int RBITS = 4,
   parameter int CBITS = 4
);
   logic              _wr_en;
   logic [RBITS-1:0]  _wr_row;
   logic [CBITS-1:0]  _wr_column;
   logic [WIDTH-1:0]  _wr_data;
   logic              _rd_en;
   logic [RBITS-1:0]  _row;
   logic [CBITS-1:0]  _column;
   logic [WIDTH-1:0]  _value;
   logic              _rd_valid;
   logic              _scan_start;
   logic              _scan_ready;
   logic              _scan_valid;
   logic [WIDTH-1:0]  _scan_data;
   logic [RBITS-1:0]  _scan_row;
   logic [CBITS-1:0]  _scan_column;
   logic              _scan_last;
   logic              _busy;

   modport master (
      output _wr_en, _wr_row, _wr_column, _wr_data,
      output _rd_en, _row, _column,
      output _scan_start, _scan_ready,
      input  _value, _rd_valid,
      input  _scan_valid, _scan_data, _scan_row, _scan_column, _scan_last,
      input  _busy
   );

   modport slave (
      input  _wr_en, _wr_row, _wr_column, _wr_data,
      input  _rd_en, _row, _column,
      input  _scan_start, _scan_ready,
      output _value, _rd_valid,
      output _scan_valid, _scan_data, _scan_row, _scan_column, _scan_last,
      output _busy
   );
endinterface

// File: rtl/mem_array_scan.sv
// ---------------------------------------------------------------------------
// mem_array_scan
//   ROWS x COLS grid of WIDTH-bit cells with a random-access write port, a
//   registered random-access read port (latency 1) and a scan engine that
//   streams every cell in row-major order over a valid/ready handshake.
//
//   Ports
//     _clock : single rising-edge clock
//     _reset : synchronous, active-high; clears every cell, every output
//              and returns the scan engine to IDLE
//     bus    : mem_array_scan_if.slave (write, read, scan stream, _busy)
//
//   Every array read (random read and scan capture) samples the contents
//   from before the clock edge, so a same-edge write is never visible to a
//   same-edge read.
// ---------------------------------------------------------------------------
module mem_array_scan #(
   parameter int WIDTH = 8,
   parameter int ROWS  = 16,
   parameter int COLS  = 16,
   parameter int RBITS = 4,
   parameter int CBITS = 4
) (
   input  logic                _clock,
   input  logic                _reset,
   mem_array_scan_if.slave     bus
);

   localparam int DEPTH = ROWS * COLS;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [RBITS-1:0] LAST_ROW = RBITS'(ROWS - 1);
   localparam logic [CBITS-1:0] LAST_COL = CBITS'(COLS - 1);
   localparam logic [RBITS:0]   ROW_LIM  = (RBITS+1)'(ROWS);
   localparam logic [CBITS:0]   COL_LIM  = (CBITS+1)'(COLS);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   // Cell storage, flattened row-major.
   logic [WIDTH-1:0] cells [DEPTH];

   // Row/column range checks are widened by one bit so that a full-range
   // address field (ROWS == 2**RBITS) still compares meaningfully.
   function automatic logic row_ok(input logic [RBITS-1:0] r);
      return ({1'b0, r} < ROW_LIM);
   endfunction

   function automatic logic col_ok(input logic [CBITS-1:0] c);
      return ({1'b0, c} < COL_LIM);
   endfunction

   function automatic logic [AW-1:0] cell_idx(input logic [RBITS-1:0] r,
                                              input logic [CBITS-1:0] c);
      return AW'(int'(r) * COLS + int'(c));
   endfunction

   // -------------------------------------------------------------------
   // Write port
   // -------------------------------------------------------------------
   always_ff @(posedge _clock) begin
      if (_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            cells[i] <= '0;
         end
      end else if (bus._wr_en && row_ok(bus._wr_row) && col_ok(bus._wr_column)) begin
         cells[cell_idx(bus._wr_row, bus._wr_column)] <= bus._wr_data;
      end
   end

   // -------------------------------------------------------------------
   // Read port: p0 = address on the bus, p1 = registered result
   // -------------------------------------------------------------------
   logic [WIDTH-1:0] rd_data_p1;
   logic             rd_vld_p1;

   always_ff @(posedge _clock) begin
      if (_reset) begin
         rd_data_p1 <= '0;
         rd_vld_p1  <= 1'b0;
      end else if (bus._rd_en) begin
         rd_vld_p1 <= 1'b1;
         // Out-of-range reads return zero but still pulse valid.
         if (row_ok(bus._row) && col_ok(bus._column)) begin
            rd_data_p1 <= cells[cell_idx(bus._row, bus._column)];
         end else begin
            rd_data_p1 <= '0;
         end
      end else begin
         // _value holds; only the valid pulse drops.
         rd_vld_p1 <= 1'b0;
      end
   end

   assign bus._value    = rd_data_p1;
   assign bus._rd_valid = rd_vld_p1;

   // -------------------------------------------------------------------
   // Scan engine
   // -------------------------------------------------------------------
   state_t           state;
   logic             scan_vld_p1;
   logic [WIDTH-1:0] scan_data_p1;
   logic [RBITS-1:0] scan_row_p1;
   logic [CBITS-1:0] scan_col_p1;
   logic             scan_last_p1;
   logic             busy_p1;

   logic [RBITS-1:0] adv_row;
   logic [CBITS-1:0] adv_col;
   logic             adv_last;
   logic             handshake;

   // Address of the beat that follows the one currently presented.
   always_comb begin
      adv_row = scan_row_p1;
      adv_col = scan_col_p1;
      if (scan_col_p1 == LAST_COL) begin
         adv_col = '0;
         adv_row = scan_row_p1 + 1'b1;
      end else begin
         adv_col = scan_col_p1 + 1'b1;
      end
      adv_last = (adv_row == LAST_ROW) && (adv_col == LAST_COL);
   end

   assign handshake = scan_vld_p1 && bus._scan_ready;

   always_ff @(posedge _clock) begin
      if (_reset) begin
         state        <= IDLE;
         scan_vld_p1  <= 1'b0;
         scan_data_p1 <= '0;
         scan_row_p1  <= '0;
         scan_col_p1  <= '0;
         scan_last_p1 <= 1'b0;
         busy_p1      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus._scan_start) begin
                  state        <= SCAN;
                  busy_p1      <= 1'b1;
                  scan_vld_p1  <= 1'b1;
                  scan_row_p1  <= '0;
                  scan_col_p1  <= '0;
                  scan_data_p1 <= cells[cell_idx('0, '0)];
                  // A 1x1 array presents its only beat as the last one.
                  scan_last_p1 <= (DEPTH == 1);
               end
            end
            SCAN: begin
               // Without a handshake the beat (including its data) is held,
               // even if the presented cell is overwritten meanwhile.
               if (handshake) begin
                  if (scan_last_p1) begin
                     // _scan_start on this edge is deliberately not honoured.
                     state        <= IDLE;
                     busy_p1      <= 1'b0;
                     scan_vld_p1  <= 1'b0;
                     scan_last_p1 <= 1'b0;
                  end else begin
                     scan_row_p1  <= adv_row;
                     scan_col_p1  <= adv_col;
                     scan_data_p1 <= cells[cell_idx(adv_row, adv_col)];
                     scan_last_p1 <= adv_last;
                  end
               end
            end
            default: begin
               state        <= IDLE;
               busy_p1      <= 1'b0;
               scan_vld_p1  <= 1'b0;
               scan_last_p1 <= 1'b0;
            end
         endcase
      end
   end

   assign bus._scan_valid  = scan_vld_p1;
   assign bus._scan_data   = scan_data_p1;
   assign bus._scan_row    = scan_row_p1;
   assign bus._scan_column = scan_col_p1;
   assign bus._scan_last   = scan_last_p1;
   assign bus._busy        = busy_p1;

endmodule

// File: tb/tb_mem_array_scan.sv
// ---------------------------------------------------------------------------
// tb_mem_array_scan
//   Scoreboard bench for mem_array_scan. A reference model updated on each
//   rising edge pushes expected read results and scan beats into queues; a
//   monitor on the falling edge compares the DUT outputs against the queue
//   fronts. Row address width is one bit wider than needed so row 16 (out of
//   range for ROWS=16) can be driven.
// ---------------------------------------------------------------------------
module tb_mem_array_scan;

   localparam int WIDTH = 8;
   localparam int ROWS  = 16;
   localparam int COLS  = 16;
   localparam int RBITS = 5;
   localparam int CBITS = 4;
   localparam int TOTAL = ROWS * COLS;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [RBITS-1:0] row;
      logic [CBITS-1:0] col;
      logic             last;
   } beat_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mem_array_scan_if #(.WIDTH(WIDTH), .RBITS(RBITS), .CBITS(CBITS)) bus ();

   mem_array_scan #(
      .WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS), .RBITS(RBITS), .CBITS(CBITS)
   ) dut (
      ._clock(clk),
      ._reset(rst),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [WIDTH-1:0] mdl [ROWS][COLS];
   logic [WIDTH-1:0] exp_val;
   logic [WIDTH-1:0] rd_q [$];
   beat_t            sc_q [$];
   bit               sc_act;
   int               sc_k;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic beat_t mk_beat(input int k);
      beat_t b;
      b.row  = RBITS'(k / COLS);
      b.col  = CBITS'(k % COLS);
      b.data = mdl[k / COLS][k % COLS];
      b.last = (k == TOTAL - 1);
      return b;
   endfunction

   // Reference model: reads and scan captures use pre-edge contents,
   // then the write is applied.
   always @(posedge clk) begin
      int r;
      int c;
      if (rst) begin
         for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
               mdl[i][j] = '0;
         sc_act  = 1'b0;
         sc_k    = 0;
         exp_val = '0;
         rd_q.delete();
         sc_q.delete();
      end else begin
         if (bus._rd_en) begin
            r = int'(bus._row);
            c = int'(bus._column);
            exp_val = (r < ROWS && c < COLS) ? mdl[r][c] : '0;
            rd_q.push_back(exp_val);
         end
         if (!sc_act) begin
            if (bus._scan_start) begin
               sc_act = 1'b1;
               sc_k   = 0;
               sc_q.push_back(mk_beat(0));
            end
         end else if (bus._scan_ready) begin
            if (sc_k == TOTAL - 1) begin
               sc_act = 1'b0;
            end else begin
               sc_k++;
               sc_q.push_back(mk_beat(sc_k));
            end
         end
         if (bus._wr_en) begin
            r = int'(bus._wr_row);
            c = int'(bus._wr_column);
            if (r < ROWS && c < COLS) mdl[r][c] = bus._wr_data;
         end
      end
   end

   // Monitor: outputs are stable here, inputs are those for the next edge.
   always @(negedge clk) begin
      bit sv_exp;
      sv_exp = (sc_q.size() != 0);
      chk("scan_valid", 64'(bus._scan_valid), 64'(sv_exp));
      chk("busy", 64'(bus._busy), 64'(sv_exp));
      if (sv_exp) begin
         chk("scan_beat",
             64'({bus._scan_data, bus._scan_row, bus._scan_column, bus._scan_last}),
             64'(sc_q[0]));
         if (bus._scan_ready) void'(sc_q.pop_front());
      end else begin
         chk("scan_last_idle", 64'(bus._scan_last), 64'(0));
      end
      chk("rd_valid", 64'(bus._rd_valid), 64'(rd_q.size() != 0));
      chk("value", 64'(bus._value), 64'(exp_val));
      if (rd_q.size() != 0) void'(rd_q.pop_front());
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus._wr_en      = 1'b0;
      bus._wr_row     = '0;
      bus._wr_column  = '0;
      bus._wr_data    = '0;
      bus._rd_en      = 1'b0;
      bus._row        = '0;
      bus._column     = '0;
      bus._scan_start = 1'b0;
   endtask

   task automatic wr(input int r, input int c, input int d);
      bus._wr_en     = 1'b1;
      bus._wr_row    = RBITS'(r);
      bus._wr_column = CBITS'(c);
      bus._wr_data   = WIDTH'(d);
   endtask

   task automatic rd(input int r, input int c);
      bus._rd_en  = 1'b1;
      bus._row    = RBITS'(r);
      bus._column = CBITS'(c);
   endtask

   // mode 0: ready held high; mode 1: ready 1,0,0 with writes to the held
   // cell and a later cell; mode 2: random ready, random traffic, stray
   // starts (including one on the final handshake edge).
   task automatic run_scan(input int mode);
      int n;
      clr();
      bus._scan_start = 1'b1;
      bus._scan_ready = 1'b1;
      step();
      n = 0;
      while (bus._busy && n < 4 * TOTAL + 20) begin
         clr();
         case (mode)
            0: bus._scan_ready = 1'b1;
            1: begin
               bus._scan_ready = (n % 3 == 0);
               if (n == 4) wr(15, 15, 8'h77);
               if (n == 7) wr(sc_k / COLS, sc_k % COLS, 8'h77);
            end
            default: begin
               bus._scan_ready = 1'($urandom % 2);
               if ($urandom % 2 == 1)
                  wr($urandom_range(ROWS + 1, 0), $urandom_range(COLS - 1, 0), $urandom);
               if ($urandom % 2 == 1)
                  rd($urandom_range(ROWS + 1, 0), $urandom_range(COLS - 1, 0));
               if (sc_k < TOTAL - 5 && $urandom % 4 == 0) bus._scan_start = 1'b1;
               if (sc_k == TOTAL - 1) begin
                  bus._scan_ready = 1'b1;
                  bus._scan_start = 1'b1;
               end
            end
         endcase
         step();
         n++;
      end
      clr();
      bus._scan_ready = 1'b0;
      chk("scan_done_timeout", 64'(bus._busy), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog_timeout got running want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      clr();
      bus._scan_ready = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      chk("reset_value", 64'(bus._value), 64'(0));
      chk("reset_busy", 64'(bus._busy), 64'(0));

      // Read after reset, then write/read back
      rd(1, 5); step(); clr();
      chk("t1_read_zero", 64'(bus._value), 64'(0));
      chk("t1_rd_valid", 64'(bus._rd_valid), 64'(1));
      wr(1, 5, 8'hA5); step(); clr();
      rd(1, 5); step(); clr();
      chk("t1_read_a5", 64'(bus._value), 64'hA5);

      // Same-edge write and read return old data
      wr(2, 2, 8'h11); step(); clr();
      wr(2, 2, 8'h3C); rd(2, 2); step(); clr();
      chk("t2_old_data", 64'(bus._value), 64'h11);
      rd(2, 2); step(); clr();
      chk("t2_new_data", 64'(bus._value), 64'h3C);

      // Out-of-range write leaves cells alone; out-of-range read is zero
      wr(16, 0, 8'hFF); step(); clr();
      for (int r = 0; r < ROWS; r++) begin
         rd(r, 0); step(); clr();
      end
      rd(16, 0); step(); clr();
      chk("t3_oob_read", 64'(bus._value), 64'(0));
      chk("t3_oob_valid", 64'(bus._rd_valid), 64'(1));
      step();
      chk("t3_valid_drop", 64'(bus._rd_valid), 64'(0));

      // Fill with 16*r+c and stream at full rate
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            wr(r, c, 16 * r + c); step(); clr();
         end
      run_scan(0);

      // Stalling consumer with writes to held and later cells
      run_scan(1);

      // Random traffic outside and during a scan
      for (int i = 0; i < 300; i++) begin
         clr();
         if ($urandom % 2 == 1)
            wr($urandom_range(ROWS + 1, 0), $urandom_range(COLS - 1, 0), $urandom);
         if ($urandom % 2 == 1)
            rd($urandom_range(ROWS + 1, 0), $urandom_range(COLS - 1, 0));
         step();
      end
      run_scan(2);

      // Reset in the middle of a scan
      clr();
      bus._scan_start = 1'b1;
      bus._scan_ready = 1'b1;
      step();
      bus._scan_start = 1'b0;
      repeat (40) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t6_valid_after_reset", 64'(bus._scan_valid), 64'(0));
      chk("t6_busy_after_reset", 64'(bus._busy), 64'(0));
      step();
      run_scan(0);

      step();
      step();
      chk("scan_queue_drained", 64'(sc_q.size()), 64'(0));
      chk("read_queue_drained", 64'(rd_q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
